// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   Buffered 8-bit UART transmitter. Bytes written through the write port are
//   queued in a circular FIFO. Each byte is sent as a start bit, eight data bits
//   (LSB first), an optional parity bit and one or two stop bits. Each bit lasts
//   SYS_CLK_FREQ/BAUD_RATE clocks.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset; aborts any frame, line goes high
//   wr_en     write strobe; byte accepted when wr_en && !full
//   wr_data   byte to transmit, sampled only on the accepting edge
//   full      FIFO holds 2**FIFO_DEPTH_LOG2 bytes
//   count     bytes waiting in the FIFO (the byte on the wire is not counted)
//   overflow  one-cycle pulse after a write that found the FIFO full
//   busy      transmitter active or bytes still queued
//   tx        registered serial output, idles high
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int SYS_CLK_FREQ    = 100_000_000,
  parameter int BAUD_RATE       = 115200,
  parameter int PARITY_MODE     = 0,
  parameter int STOP_BITS       = 1,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic [FIFO_DEPTH_LOG2:0] count,
  output logic                     overflow,
  output logic                     busy,
  output logic                     tx
);

  localparam int BIT_CYC = SYS_CLK_FREQ / BAUD_RATE;
  localparam int DEPTH   = 1 << FIFO_DEPTH_LOG2;
  localparam int CW      = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;

  localparam logic [CW-1:0]            BAUD_MAX   = CW'(BIT_CYC - 1);
  localparam logic [2:0]               STOP_LAST  = 3'(STOP_BITS - 1);
  localparam logic [FIFO_DEPTH_LOG2:0] COUNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                     state, state_n;
  logic [CW-1:0]              baud_cnt, baud_n;
  logic [2:0]                 bit_idx, idx_n;
  logic [7:0]                 shreg, shreg_n;
  logic                       par_q;
  logic                       tx_n;
  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [7:0]                 head;
  logic                       push, pop, bit_end;

  // The head byte is always visible so a pop can load the shift register and
  // compute parity in the same cycle it leaves the FIFO.
  assign head    = mem[rd_ptr];
  assign full    = (count == COUNT_FULL);
  assign push    = wr_en && !full;
  assign busy    = (state != IDLE) || (count != '0);
  assign bit_end = (baud_cnt == BAUD_MAX);

  // Next-state logic. The baud counter free-runs through every bit period and
  // sits at zero in IDLE. tx is computed one cycle ahead so the output pin is a
  // plain flop. From the last stop cycle we pop straight into START when more
  // bytes are waiting, which gives back-to-back frames with no idle gap.
  always_comb begin
    state_n = state;
    baud_n  = bit_end ? '0 : baud_cnt + 1'b1;
    idx_n   = bit_idx;
    shreg_n = shreg;
    tx_n    = tx;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        baud_n = '0;
        if (count != '0) begin
          pop     = 1'b1;
          shreg_n = head;
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          tx_n    = shreg[0];
          idx_n   = 3'd0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
            idx_n = 3'd0;
            if (PARITY_MODE != 0) begin
              tx_n    = par_q;
              state_n = PARITY;
            end else begin
              tx_n    = 1'b1;
              state_n = STOP;
            end
          end else begin
            shreg_n = {1'b0, shreg[7:1]};
            tx_n    = shreg[1];
            idx_n   = bit_idx + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          tx_n    = 1'b1;
          idx_n   = 3'd0;
          state_n = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_idx == STOP_LAST) begin
            idx_n = 3'd0;
            if (count != '0) begin
              pop     = 1'b1;
              shreg_n = head;
              tx_n    = 1'b0;
              state_n = START;
            end else begin
              tx_n    = 1'b1;
              state_n = IDLE;
            end
          end else begin
            idx_n = bit_idx + 3'd1;
          end
        end
      end
      default: begin
        tx_n    = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  // Control and FIFO bookkeeping registers. Parity is latched from the byte as
  // it is popped, because the shift register is consumed while data goes out.
  // A write that meets a full FIFO is dropped even if a pop happens that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shreg    <= 8'd0;
      par_q    <= 1'b0;
      tx       <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= idx_n;
      shreg    <= shreg_n;
      tx       <= tx_n;
      overflow <= wr_en && full;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        par_q  <= (PARITY_MODE == 1) ? ~^head : ^head;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Byte storage; no reset needed since count guards every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Self-checking bench for uart_tx_fifo. Four instances share clock and reset:
//   0 = no parity / 1 stop, 1 = even parity, 2 = odd parity, 3 = 2 stop bits.
//   A frame-level reference model (byte queue + frame timeline) predicts every
//   output each cycle; directed checks pin exact bit positions and corner cases.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int BIT_CYC = 16;
  localparam int PAR [4] = '{0, 2, 1, 0};
  localparam int STP [4] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] wr_en_v = 4'b0;
  logic [7:0] wd [4];
  logic [3:0] tx_v, full_v, ovf_v, busy_v;
  logic [4:0] cnt_v [4];

  int  tests = 0;
  int  fails = 0;
  bit  checking = 1'b0;

  logic [7:0] mmem [4][64];
  int         mhead [4];
  int         msize [4];
  bit         mact [4];
  int         mt [4];
  logic [7:0] mcur [4];
  bit         movf [4];

  bit tr [4][0:239];
  bit bs [4][0:239];

  // Clock: period 10, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx_fifo #(
      .SYS_CLK_FREQ   (1600),
      .BAUD_RATE      (100),
      .PARITY_MODE    (PAR[g]),
      .STOP_BITS      (STP[g]),
      .FIFO_DEPTH_LOG2(4)
    ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en_v[g]),
      .wr_data (wd[g]),
      .full    (full_v[g]),
      .count   (cnt_v[g]),
      .overflow(ovf_v[g]),
      .busy    (busy_v[g]),
      .tx      (tx_v[g])
    );
  end

  function automatic int flen(input int i);
    return (10 + ((PAR[i] != 0) ? 1 : 0) + STP[i] - 1) * BIT_CYC;
  endfunction

  // Expected line level: position inside the frame decides which bit is on the wire.
  function automatic int expTx(input int i);
    int         b;
    logic [7:0] d;
    if (!mact[i]) return 1;
    d = mcur[i];
    b = mt[i] / BIT_CYC;
    if (b == 0) return 0;
    if (b <= 8) return int'(d[b-1]);
    if (PAR[i] != 0 && b == 9) return (PAR[i] == 2) ? int'(^d) : int'(~^d);
    return 1;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < 4; i++) begin
      mhead[i] = 0;
      msize[i] = 0;
      mact[i]  = 1'b0;
      mt[i]    = 0;
      movf[i]  = 1'b0;
    end
  endtask

  // One clock edge of the reference: accept into the queue unless 16 are held,
  // start a new frame when idle or at the last cycle of a frame if bytes were waiting.
  task automatic stepModel();
    int pre;
    bit ending;
    if (!rst_n) begin
      resetModel();
    end else begin
      for (int i = 0; i < 4; i++) begin
        pre     = msize[i];
        movf[i] = wr_en_v[i] && (pre == 16);
        if (wr_en_v[i] && pre < 16) begin
          mmem[i][(mhead[i] + pre) % 64] = wd[i];
          msize[i]++;
        end
        ending = mact[i] && (mt[i] == flen(i) - 1);
        if ((!mact[i] || ending) && pre != 0) begin
          mcur[i]  = mmem[i][mhead[i]];
          mhead[i] = (mhead[i] + 1) % 64;
          msize[i]--;
          mact[i]  = 1'b1;
          mt[i]    = 0;
        end else if (ending) begin
          mact[i] = 1'b0;
        end else if (mact[i]) begin
          mt[i]++;
        end
      end
    end
  endtask

  // Compare every instance against the model on every cycle out of reset.
  task automatic compareModel();
    if (rst_n && checking) begin
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("model i%0d tx", i), int'(tx_v[i]), expTx(i));
        checkOutput($sformatf("model i%0d count", i), int'(cnt_v[i]), msize[i]);
        checkOutput($sformatf("model i%0d full", i), int'(full_v[i]), (msize[i] == 16) ? 1 : 0);
        checkOutput($sformatf("model i%0d overflow", i), int'(ovf_v[i]), int'(movf[i]));
        checkOutput($sformatf("model i%0d busy", i), int'(busy_v[i]),
                    (mact[i] || msize[i] != 0) ? 1 : 0);
      end
    end
  endtask

  // Advance one cycle: model follows the rising edge, outputs checked on the falling edge.
  task automatic tick();
    @(posedge clk);
    stepModel();
    @(negedge clk);
    compareModel();
  endtask

  // Write one byte to the instances in mask; accepted on the next rising edge.
  task automatic applyStimulus(input logic [3:0] mask, input logic [7:0] data);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        wr_en_v[i] = 1'b1;
        wd[i]      = data;
      end
    end
    tick();
    wr_en_v = 4'b0;
  endtask

  task automatic recordTrace(input int len, input int inject_at, input logic [7:0] inj);
    for (int n = 0; n < len; n++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        tr[i][n] = tx_v[i];
        bs[i][n] = busy_v[i];
      end
      if (n == inject_at) begin
        wr_en_v[3] = 1'b1;
        wd[3]      = inj;
      end
      if (n == inject_at + 1) wr_en_v[3] = 1'b0;
    end
  endtask

  task automatic waitIdle(input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 6000 && !ok; n++) begin
      tick();
      ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (mact[i] || msize[i] != 0) ok = 1'b0;
      end
    end
    checkOutput({name, " drain timeout"}, int'(ok), 1);
  endtask

  // Stop one cycle before instance 0 pops, optionally with a given queue size.
  task automatic waitPop(input int sz, input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 6000 && !ok; n++) begin
      tick();
      if (mact[0] && mt[0] == flen(0) - 1 && (sz < 0 || msize[0] == sz)) ok = 1'b1;
    end
    checkOutput({name, " wait timeout"}, int'(ok), 1);
  endtask

  initial begin
    int maxcnt;
    int ovf_pulses;
    int cnt17;
    int lows;
    for (int i = 0; i < 4; i++) wd[i] = 8'h00;
    resetModel();

    // Reset state
    repeat (3) tick();
    checkOutput("reset tx", int'(tx_v), 15);
    checkOutput("reset busy", int'(busy_v), 0);
    checkOutput("reset full", int'(full_v), 0);
    checkOutput("reset overflow", int'(ovf_v), 0);
    checkOutput("reset count", int'(cnt_v[0]), 0);
    rst_n    = 1'b1;
    checking = 1'b1;
    repeat (3) tick();

    // 1. 0x55, no parity, one stop bit
    applyStimulus(4'b0001, 8'h55);
    checkOutput("t1 tx before start", int'(tx_v[0]), 1);
    checkOutput("t1 count after write", int'(cnt_v[0]), 1);
    recordTrace(200, -1, 8'h00);
    checkOutput("t1 start first", int'(tr[0][0]), 0);
    checkOutput("t1 start last", int'(tr[0][15]), 0);
    checkOutput("t1 bit0", int'(tr[0][16]), 1);
    checkOutput("t1 bit1", int'(tr[0][32]), 0);
    checkOutput("t1 bit7", int'(tr[0][143]), 0);
    checkOutput("t1 stop", int'(tr[0][144]), 1);
    checkOutput("t1 busy before end", int'(bs[0][159]), 1);
    checkOutput("t1 busy at 160", int'(bs[0][160]), 0);
    waitIdle("t1");

    // 2. 0x07 with even (inst 1) and odd (inst 2) parity
    applyStimulus(4'b0110, 8'h07);
    recordTrace(200, -1, 8'h00);
    checkOutput("t2 even bit0", int'(tr[1][16]), 1);
    checkOutput("t2 even bit3", int'(tr[1][64]), 0);
    checkOutput("t2 even parity", int'(tr[1][144]), 1);
    checkOutput("t2 even parity end", int'(tr[1][159]), 1);
    checkOutput("t2 odd parity", int'(tr[2][144]), 0);
    checkOutput("t2 odd stop", int'(tr[2][160]), 1);
    checkOutput("t2 busy at 175", int'(bs[1][175]), 1);
    checkOutput("t2 busy at 176", int'(bs[1][176]), 0);
    waitIdle("t2");

    // 3. 0xA3 with two stop bits, second byte 0x5C queued mid-frame
    applyStimulus(4'b1000, 8'hA3);
    recordTrace(240, 20, 8'h5C);
    checkOutput("t3 bit0", int'(tr[3][16]), 1);
    checkOutput("t3 bit2", int'(tr[3][48]), 0);
    checkOutput("t3 stop first", int'(tr[3][144]), 1);
    checkOutput("t3 stop second", int'(tr[3][160]), 1);
    checkOutput("t3 stop last", int'(tr[3][175]), 1);
    checkOutput("t3 next start", int'(tr[3][176]), 0);
    checkOutput("t3 next bit0", int'(tr[3][192]), 0);
    checkOutput("t3 next bit2", int'(tr[3][224]), 1);
    waitIdle("t3");

    // 4. Fill: 18 back-to-back writes; 17 fit (one popped on the 2nd edge)
    maxcnt     = 0;
    ovf_pulses = 0;
    cnt17      = 0;
    for (int k = 0; k < 18; k++) begin
      tick();
      if (int'(cnt_v[0]) > maxcnt) maxcnt = int'(cnt_v[0]);
      ovf_pulses += int'(ovf_v[0]);
      if (k == 1) checkOutput("t4 count after edge1", int'(cnt_v[0]), 1);
      if (k == 1) checkOutput("t4 tx after edge1", int'(tx_v[0]), 1);
      if (k == 2) checkOutput("t4 tx after edge2", int'(tx_v[0]), 0);
      if (k == 17) cnt17 = int'(cnt_v[0]);
      wr_en_v[0] = 1'b1;
      wd[0]      = 8'h10 + 8'(k);
    end
    tick();
    wr_en_v[0] = 1'b0;
    checkOutput("t4 count after 17", cnt17, 16);
    checkOutput("t4 overflow on 18th", int'(ovf_v[0]), 1);
    checkOutput("t4 full", int'(full_v[0]), 1);
    for (int n = 0; n < 30; n++) begin
      if (int'(cnt_v[0]) > maxcnt) maxcnt = int'(cnt_v[0]);
      ovf_pulses += int'(ovf_v[0]);
      tick();
    end
    checkOutput("t4 overflow pulses", ovf_pulses, 1);
    checkOutput("t4 max count", maxcnt, 16);

    // 6. Write and pop in the same cycle, first while full, then at count 3
    waitPop(-1, "t6 full");
    checkOutput("t6 count before", int'(cnt_v[0]), 16);
    wr_en_v[0] = 1'b1;
    wd[0]      = 8'hEE;
    tick();
    wr_en_v[0] = 1'b0;
    checkOutput("t6 full overflow", int'(ovf_v[0]), 1);
    checkOutput("t6 full count", int'(cnt_v[0]), 15);
    waitPop(3, "t6 three");
    wr_en_v[0] = 1'b1;
    wd[0]      = 8'h33;
    tick();
    wr_en_v[0] = 1'b0;
    checkOutput("t6 three count", int'(cnt_v[0]), 3);
    checkOutput("t6 three overflow", int'(ovf_v[0]), 0);
    waitIdle("t6");
    checkOutput("t6 busy after drain", int'(busy_v[0]), 0);

    // 5. Reset during data bit 3 of a 0x00 frame with one byte still queued
    applyStimulus(4'b0001, 8'h00);
    applyStimulus(4'b0001, 8'h81);
    begin
      bit ok = 1'b0;
      for (int n = 0; n < 300 && !ok; n++) begin
        tick();
        if (mact[0] && mt[0] == 70) ok = 1'b1;
      end
      checkOutput("t5 wait timeout", int'(ok), 1);
    end
    checkOutput("t5 tx low before reset", int'(tx_v[0]), 0);
    #2;
    rst_n = 1'b0;
    resetModel();
    #1;
    checkOutput("t5 tx in reset", int'(tx_v[0]), 1);
    checkOutput("t5 count in reset", int'(cnt_v[0]), 0);
    checkOutput("t5 busy in reset", int'(busy_v[0]), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    lows  = 0;
    for (int n = 0; n < 520; n++) begin
      tick();
      if (tx_v[0] == 1'b0) lows++;
    end
    checkOutput("t5 idle low cycles", lows, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
